// File: rtl/operand_sel_pipe.sv
// operand_sel_pipe: dual operand select with writeback forwarding and a registered valid/ready output stage
module operand_sel_pipe #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int SEL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREG*WIDTH-1:0] regs_flat,
    input  logic [WIDTH-1:0]      imm_val,
    input  logic [SEL_W-1:0]      sel_a,
    input  logic [SEL_W-1:0]      sel_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  wb_en,
    input  logic [SEL_W-1:0]      wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    output logic [WIDTH-1:0]      out_a,
    output logic [WIDTH-1:0]      out_b,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           byp_count
);
    localparam logic [SEL_W-1:0] IMM_SEL = SEL_W'(NREG);

    // padded to the full select space so every code indexes a defined (zero) entry
    logic [WIDTH-1:0] regs [2**SEL_W];
    for (genvar g = 0; g < 2**SEL_W; g++) begin : g_regs
        if (g < NREG) begin : g_live
            assign regs[g] = regs_flat[g*WIDTH +: WIDTH];
        end else begin : g_pad
            assign regs[g] = '0;
        end
    end

    logic             ill_a, ill_b, imm_a, imm_b, fwd_a, fwd_b, acc;
    logic [SEL_W-1:0] eff_a, eff_b;
    logic [WIDTH-1:0] val_a, val_b;
    logic [16:0]      cnt_sum;

    always_comb begin
        ill_a   = sel_a > IMM_SEL;
        ill_b   = sel_b > IMM_SEL;
        imm_a   = sel_a == IMM_SEL;
        imm_b   = sel_b == IMM_SEL;
        eff_a   = ill_a ? '0 : sel_a;
        eff_b   = ill_b ? '0 : sel_b;
        fwd_a   = !imm_a && wb_en && wb_addr == eff_a;
        fwd_b   = !imm_b && wb_en && wb_addr == eff_b;
        val_a   = imm_a ? imm_val : fwd_a ? wb_data : regs[eff_a];
        val_b   = imm_b ? imm_val : fwd_b ? wb_data : regs[eff_b];
        cnt_sum = {1'b0, byp_count} + {16'd0, fwd_a} + {16'd0, fwd_b};
    end

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_a     <= '0;
            out_b     <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            byp_count <= '0;
        end else if (acc) begin
            out_a     <= val_a;
            out_b     <= val_b;
            out_err   <= ill_a || ill_b;
            out_valid <= 1'b1;
            byp_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_sel_pipe.sv
// tb_operand_sel_pipe: directed scoreboard bench for operand_sel_pipe
module tb_operand_sel_pipe;
    localparam int W = 16, N = 8, S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, wb_en, out_err, out_valid, out_ready;
    logic [W-1:0] regs [N];
    logic [N*W-1:0] regs_flat;
    logic [W-1:0] imm_val, wb_data, out_a, out_b;
    logic [S-1:0] sel_a, sel_b, wb_addr;
    logic [15:0]  byp_count;

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < N; i++) regs_flat[i*W +: W] = regs[i];
    end

    operand_sel_pipe #(.WIDTH(W), .NREG(N), .SEL_W(S)) dut (
        .clk(clk), .rst(rst), .regs_flat(regs_flat), .imm_val(imm_val),
        .sel_a(sel_a), .sel_b(sel_b), .in_valid(in_valid), .in_ready(in_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_a(out_a), .out_b(out_b), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready), .byp_count(byp_count)
    );

    typedef struct { logic [15:0] a; logic [15:0] b; logic e; } exp_t;
    exp_t        q[$];
    int          tests = 0, fails = 0;
    logic        m_valid = 1'b0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pick(input logic [3:0] s, output logic f);
        logic [3:0] r;
        f = 1'b0;
        if (s == 4'd8) return imm_val;
        r = (s > 4'd8) ? 4'd0 : s;
        f = wb_en && (wb_addr == r);
        return f ? wb_data : regs[r[2:0]];
    endfunction

    task automatic cyc;
        logic        fa, fb;
        exp_t        e;
        logic [16:0] s;
        @(negedge clk);
        chk("in_ready", in_ready, !m_valid || out_ready);
        if (m_valid && q.size() > 0) begin
            chk("out_a", out_a, q[0].a);
            chk("out_b", out_b, q[0].b);
            chk("out_err", out_err, q[0].e);
            if (out_ready) void'(q.pop_front());
        end
        if (in_valid && (!m_valid || out_ready)) begin
            e.a = pick(sel_a, fa);
            e.b = pick(sel_b, fb);
            e.e = (sel_a > 4'd8) || (sel_b > 4'd8);
            q.push_back(e);
            s = {1'b0, exp_cnt} + 17'(fa) + 17'(fb);
            exp_cnt = s[16] ? 16'hFFFF : s[15:0];
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("byp_count", byp_count, exp_cnt);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; out_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        imm_val = 0; sel_a = 0; sel_b = 0;
        for (int i = 0; i < N; i++) regs[i] = '0;
        #12;
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_byp_count", byp_count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        regs[3] = 16'h1234; regs[5] = 16'hBEEF;
        sel_a = 3; sel_b = 5; in_valid = 1; out_ready = 1;
        cyc;
        chk("basic_a", out_a, 16'h1234);
        chk("basic_b", out_b, 16'hBEEF);
        chk("basic_err", out_err, 0);

        sel_a = 8; imm_val = 16'h00FF; sel_b = 12; regs[0] = 16'hAAAA;
        cyc;
        chk("imm_a", out_a, 16'h00FF);
        chk("ill_b", out_b, 16'hAAAA);
        chk("ill_err", out_err, 1);

        regs[2] = 16'h0001; wb_en = 1; wb_addr = 2; wb_data = 16'h7777; sel_a = 2; sel_b = 2;
        cyc;
        chk("fwd_a", out_a, 16'h7777);
        chk("fwd_b", out_b, 16'h7777);
        chk("fwd_cnt", byp_count, 2);

        wb_addr = 8; sel_a = 8; sel_b = 0;
        cyc;
        chk("imm_nofwd_a", out_a, 16'h00FF);
        chk("imm_nofwd_cnt", byp_count, 2);

        sel_a = 15; sel_b = 3; wb_addr = 0; wb_data = 16'h5555;
        cyc;
        chk("ill_fwd_a", out_a, 16'h5555);
        chk("ill_fwd_b", out_b, 16'h1234);
        chk("ill_fwd_cnt", byp_count, 3);

        wb_en = 0; sel_a = 3; sel_b = 5;
        cyc;
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            sel_a = 1; regs[3] = 16'h9999 + 16'(i); wb_en = 1; wb_addr = 3; wb_data = 16'h3333;
            cyc;
            chk("stall_a", out_a, 16'h1234);
            chk("stall_b", out_b, 16'hBEEF);
            chk("stall_ready", in_ready, 0);
        end
        wb_en = 0; regs[1] = 16'h0101; out_ready = 1;
        cyc;
        chk("release_a", out_a, 16'h0101);

        for (int i = 0; i < N; i++) regs[i] = 16'h1000 + 16'(i);
        for (int i = 0; i < 10; i++) begin
            sel_a = 4'(i % 8); sel_b = 4'((i + 1) % 8);
            cyc;
        end
        in_valid = 0;
        cyc;
        cyc;
        chk("drain_valid", out_valid, 0);

        wb_en = 1; wb_addr = 4; sel_a = 4; sel_b = 4; in_valid = 1;
        repeat (32768) cyc;
        chk("sat_cnt", byp_count, 16'hFFFF);

        out_ready = 0;
        cyc;
        cyc;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_cnt", byp_count, 0);
        chk("arst_a", out_a, 0);
        q.delete(); m_valid = 1'b0; exp_cnt = 16'd0;
        in_valid = 0; out_ready = 1; wb_en = 0;
        @(negedge clk);
        rst = 1'b0;
        cyc;
        chk("no_replay", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/operand_sel_pipe.md
Name: operand_sel_pipe

Overview:
- Parametrised, registered successor to the CPU's combinational operand mux.
- Selects two source operands (A and B) in parallel. Each comes from NREG register-file outputs or the immediate.
- Forwards in-flight writeback data and flags illegal selects.
- Presents results through a one-stage valid/ready output register between decode and the ALU.

Parameters:
- WIDTH, 16, datapath width of registers, immediate and operands.
- NREG, 8, number of register inputs; legal range 2..15.
- SEL_W, 4, select width. Must satisfy 2**SEL_W > NREG, so code NREG is reachable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- regs_flat  in  NREG*WIDTH  register values; register i occupies bits [i*WIDTH +: WIDTH].
- imm_val  in  WIDTH  immediate operand.
- sel_a  in  SEL_W  operand A select: 0..NREG-1 is a register, NREG is the immediate, above NREG is illegal.
- sel_b  in  SEL_W  operand B select, same encoding as sel_a.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- wb_en  in  1  writeback in progress this cycle.
- wb_addr  in  SEL_W  writeback destination register.
- wb_data  in  WIDTH  writeback value.
- out_a  out  WIDTH  registered operand A.
- out_b  out  WIDTH  registered operand B.
- out_err  out  1  registered flag: either select was illegal.
- out_valid  out  1  operands valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- byp_count  out  16  saturating count of forwarded operands.

Behaviour:
- Reset (async, rst=1): out_a=0, out_b=0, out_err=0, out_valid=0, byp_count=0. Reset mid-transfer drops the held operand; nothing is replayed.
- in_ready = !out_valid || out_ready. This is combinational, with no bubble on back-to-back transfers.
- Accept (in_valid && in_ready): on the next rising edge, the output registers load the selected values and out_valid is set to 1.
- No accept but out_ready=1: out_valid goes to 0 and data registers hold their old values.
- Stall (out_valid=1, out_ready=0): out_a, out_b, out_err and out_valid hold their values, and in_ready=0.
- Latency: 1 cycle from accept to out_valid, at 1 transfer per cycle.
- Per-channel selection, evaluated at accept time:
  - sel < NREG and wb_en=1 and wb_addr == sel: wb_data (forward; writeback wins over the stale register).
  - sel < NREG otherwise: regs_flat slice[sel].
  - sel == NREG: imm_val. Never forwarded, even if wb_addr == NREG.
  - sel > NREG: register 0 value (forward rule still applies to register 0), and out_err=1.
- out_err = illegal(sel_a) || illegal(sel_b), registered together with the operands.
- A and B are independent; both may forward from the same writeback in one cycle.
- byp_count increments by the number of forwarded channels (0, 1 or 2) on each accept cycle only, and saturates at 16'hFFFF.
- Forwarding is not evaluated while stalled: a writeback during a stall does not alter held operands.
- No X propagation: all output registers are reset, and selects above NREG are fully decoded.

Test Plan:
- Reset/basic: rst pulse, then regs r3=16'h1234, r5=16'hBEEF; sel_a=3, sel_b=5, in_valid=1, out_ready=1 -> next cycle out_a=1234, out_b=BEEF, out_valid=1, out_err=0; during reset all outputs are 0.
- Immediate/illegal: sel_a=8, imm_val=16'h00FF; sel_b=12 with r0=16'hAAAA -> out_a=00FF, out_b=AAAA, out_err=1.
- Forwarding: r2=16'h0001, wb_en=1, wb_addr=2, wb_data=16'h7777, sel_a=2, sel_b=2 -> out_a=out_b=7777, byp_count +2. wb_addr=8 with sel_a=8 -> imm_val, no count.
- Back-pressure: accept X, hold out_ready=0 for 3 cycles while changing inputs and wb -> in_ready=0, out_a/out_b hold X; release -> next request loads the cycle after, with no data lost or duplicated.
- Throughput: 10 consecutive requests, out_ready=1 -> 10 valid outputs on consecutive cycles, in order.
- Saturation/async reset: force 0x10000 forward events -> byp_count stays FFFF; assert rst asynchronously mid-stall -> out_valid and byp_count drop to 0 immediately, before the next clk edge.
